// File: rtl/seq_check_stream_if.sv
// Player-colour stream into seq_check_stream: valid/ready handshake carrying one colour per beat.
// The master side is the input-capture block; the slave side is the round checker.
interface seq_check_stream_if #(
    parameter int COLOUR_W = 2
);
    logic                in_valid;
    logic                in_ready;
    logic [COLOUR_W-1:0] in_colour;

    modport master (output in_valid, output in_colour, input in_ready);
    modport slave  (input in_valid, input in_colour, output in_ready);
endinterface

// File: rtl/seq_check_stream.sv
// Streaming Simon Says round checker: compares player colours against the golden sequence as they arrive.
// Optional inactivity timeout is enabled by defining SEQ_CHECK_TIMEOUT_EN.
module seq_check_stream #(
    parameter int COLOUR_W       = 2,
    parameter int MAX_ROUNDS     = 16,
    parameter int RND_W          = $clog2(MAX_ROUNDS),
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en_check,
    input  logic [RND_W-1:0]               round_ctr_in,
    input  logic [COLOUR_W*MAX_ROUNDS-1:0] seq_mem,
    seq_check_stream_if.slave              bus,
    output logic [RND_W-1:0]               entry_idx,
    output logic [RND_W-1:0]               round_ctr_out,
    output logic                           complete_check,
    output logic                           pass,
    output logic                           fail,
    output logic                           game_complete,
    output logic                           rst_wait,
    output logic                           rst_display,
    output logic                           rst_idle,
    output logic                           rst_check_out
);
    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    localparam logic [RND_W-1:0] LAST_RND = RND_W'(MAX_ROUNDS - 1);

    state_t              state_q, state_d;
    logic [RND_W-1:0]    idx_q, idx_d;
    logic [RND_W-1:0]    tgt_q, tgt_d;
    logic [RND_W-1:0]    rctr_q, rctr_d;
    logic                gc_q, gc_d;
    logic                passed_q, passed_d;
    logic [COLOUR_W-1:0] expected;
    logic                accept;

`ifdef SEQ_CHECK_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    assign accept   = (state_q == COLLECT) && bus.in_valid;
    assign expected = seq_mem[int'(idx_q)*COLOUR_W +: COLOUR_W];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tgt_d    = tgt_q;
        rctr_d   = rctr_q;
        gc_d     = gc_q;
        passed_d = passed_q;
`ifdef SEQ_CHECK_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                rctr_d = round_ctr_in;
                if (en_check) begin
                    tgt_d   = (round_ctr_in > LAST_RND) ? LAST_RND : round_ctr_in;
                    idx_d   = '0;
                    state_d = COLLECT;
`ifdef SEQ_CHECK_TIMEOUT_EN
                    tmo_d   = TMO_LOAD;
`endif
                end
            end
            COLLECT: begin
                if (accept) begin
`ifdef SEQ_CHECK_TIMEOUT_EN
                    tmo_d = TMO_LOAD;
`endif
                    if (bus.in_colour != expected) begin
                        passed_d = 1'b0;
                        rctr_d   = '0;
                        gc_d     = 1'b0;
                        state_d  = DONE;
                    end else if (idx_q == tgt_q) begin
                        passed_d = 1'b1;
                        state_d  = DONE;
                        if (tgt_q == LAST_RND) begin
                            rctr_d = tgt_q;
                            gc_d   = 1'b1;
                        end else begin
                            rctr_d = tgt_q + 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
`ifdef SEQ_CHECK_TIMEOUT_EN
                else if (tmo_q == '0) begin
                    passed_d = 1'b0;
                    rctr_d   = '0;
                    gc_d     = 1'b0;
                    state_d  = DONE;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            tgt_q    <= '0;
            rctr_q   <= '0;
            gc_q     <= 1'b0;
            passed_q <= 1'b0;
`ifdef SEQ_CHECK_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tgt_q    <= tgt_d;
            rctr_q   <= rctr_d;
            gc_q     <= gc_d;
            passed_q <= passed_d;
`ifdef SEQ_CHECK_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    // Round-result pulses are decoded from DONE so they last exactly one cycle.
    assign bus.in_ready   = (state_q == COLLECT);
    assign entry_idx      = idx_q;
    assign round_ctr_out  = rctr_q;
    assign game_complete  = gc_q;
    assign complete_check = (state_q == DONE);
    assign pass           = (state_q == DONE) &&  passed_q;
    assign fail           = (state_q == DONE) && !passed_q;
    assign rst_wait       = pass;
    assign rst_display    = pass;
    assign rst_idle       = pass;
    assign rst_check_out  = pass;
endmodule
